// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 opcode, funct3, writeback-select and MEM-stage FSM types
package rv32_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    CWB_ALU = 2'b00,
    CWB_MEM = 2'b01,
    CWB_IO  = 2'b10
  } control_wb_t;

  typedef enum logic {
    S_IDLE,
    S_IO_WAIT
  } mem_state_t;

endpackage

// File: rtl/rv32_mem_if.sv
// rtl/rv32_mem_if.sv - data-memory and memory-mapped IO bus bundle for the MEM stage
interface rv32_mem_if;
  logic [29:0] memif_addr;
  logic        memif_we;
  logic [3:0]  memif_be;
  logic [31:0] memif_wdata;
  logic        io_req;
  logic        io_we;
  logic [31:0] io_addr;
  logic [3:0]  io_be;
  logic [31:0] io_wdata;
  logic        io_ack;
  logic [31:0] io_rdata;
  logic        io_err;

  modport master (
    output memif_addr, memif_we, memif_be, memif_wdata,
    output io_req, io_we, io_addr, io_be, io_wdata, io_err,
    input  io_ack, io_rdata
  );

  modport slave (
    input  memif_addr, memif_we, memif_be, memif_wdata,
    input  io_req, io_we, io_addr, io_be, io_wdata, io_err,
    output io_ack, io_rdata
  );
endinterface

// File: rtl/rv32_mem_lane.sv
// rtl/rv32_mem_lane.sv - byte-enable/store replication and load lane extract/extend
module rv32_mem_lane
  import rv32_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = load_word[7:0];
    case (addr_lo)
      2'd1:    ld_byte = load_word[15:8];
      2'd2:    ld_byte = load_word[23:16];
      2'd3:    ld_byte = load_word[31:24];
      default: ;
    endcase
    ld_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    load_data = load_word;
    case (funct3)
      F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
      F3_BU:   load_data = {24'b0, ld_byte};
      F3_HU:   load_data = {16'b0, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32_mem_top.sv
// rtl/rv32_mem_top.sv - RV32 MEM stage with IO wait-state/timeout; option RV32_MEM_MISALIGN_TRAP_EN
module rv32_mem_top
  import rv32_pkg::*;
#(
  parameter logic [3:0] IO_BASE    = 4'hF,
  parameter int         IO_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] iw_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] rs2_in,
  input  logic [4:0]  wb_reg_in,
  input  logic        wb_enable_in,
  output logic        mem_stall,
  rv32_mem_if.master  bus,
  output logic [31:0] pc_out,
  output logic [31:0] iw_out,
  output logic [31:0] alu_out,
  output logic [4:0]  wb_reg_out,
  output logic        wb_enable_out,
  output logic [1:0]  control_wb_out,
  output logic [31:0] io_rdata_out,
  output logic [4:0]  ld_fmt_out,
`ifdef RV32_MEM_MISALIGN_TRAP_EN
  output logic        misalign_out,
`endif
  output logic        df_mem_enable,
  output logic [4:0]  df_mem_reg,
  output logic [31:0] df_mem_data,
  output logic        df_mem_is_load
);

  localparam logic [7:0] TO_LAST = 8'(IO_TIMEOUT - 1);

  mem_state_t  state;
  logic [7:0]  wait_cnt;
  logic        q_we;
  logic [31:0] q_addr;
  logic [3:0]  q_be;
  logic [31:0] q_wdata;
  logic        io_err_q;

  logic [2:0]  funct3;
  logic        is_load, is_store, is_mem_op, is_io, misalign;
  logic        in_wait, io_start, timeout, io_done;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;

  assign funct3    = iw_in[14:12];
  assign is_load   = (iw_in[6:0] == OP_LOAD);
  assign is_store  = (iw_in[6:0] == OP_STORE);
  assign is_mem_op = is_load | is_store;
  assign is_io     = (alu_in[31:28] == IO_BASE);

`ifdef RV32_MEM_MISALIGN_TRAP_EN
  assign misalign = is_mem_op &&
                    ((funct3[1:0] == 2'b01 && alu_in[0]) ||
                     (funct3[1:0] == 2'b10 && alu_in[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  rv32_mem_lane u_lane (
    .funct3     (funct3),
    .addr_lo    (alu_in[1:0]),
    .store_data (rs2_in),
    .load_word  (bus.io_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (lane_rdata)
  );

  // Stall drops on the completion cycle itself so EX advances past the IO op at that edge.
  assign in_wait   = (state == S_IO_WAIT);
  assign io_start  = (state == S_IDLE) && is_mem_op && is_io && !misalign;
  assign timeout   = in_wait && (wait_cnt == TO_LAST);
  assign io_done   = (io_start && bus.io_ack) || (in_wait && (bus.io_ack || timeout));
  assign mem_stall = (io_start || in_wait) && !io_done;

  assign bus.memif_addr  = alu_in[31:2];
  assign bus.memif_we    = is_store && !is_io && !misalign;
  assign bus.memif_be    = (is_store && !is_io) ? lane_be : 4'b0000;
  assign bus.memif_wdata = lane_wdata;

  assign bus.io_req   = io_start || in_wait;
  assign bus.io_we    = in_wait ? q_we    : (io_start && is_store);
  assign bus.io_addr  = in_wait ? q_addr  : (io_start ? alu_in     : 32'b0);
  assign bus.io_be    = in_wait ? q_be    : (io_start ? lane_be    : 4'b0000);
  assign bus.io_wdata = in_wait ? q_wdata : (io_start ? lane_wdata : 32'b0);
  assign bus.io_err   = io_err_q;

  assign df_mem_enable  = wb_enable_in;
  assign df_mem_reg     = wb_reg_in;
  assign df_mem_data    = alu_in;
  assign df_mem_is_load = is_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      wait_cnt       <= 8'd0;
      q_we           <= 1'b0;
      q_addr         <= 32'b0;
      q_be           <= 4'b0;
      q_wdata        <= 32'b0;
      io_err_q       <= 1'b0;
      pc_out         <= 32'b0;
      iw_out         <= 32'b0;
      alu_out        <= 32'b0;
      wb_reg_out     <= 5'b0;
      wb_enable_out  <= 1'b0;
      control_wb_out <= CWB_ALU;
      io_rdata_out   <= 32'b0;
      ld_fmt_out     <= 5'b0;
`ifdef RV32_MEM_MISALIGN_TRAP_EN
      misalign_out   <= 1'b0;
`endif
    end else begin
      io_err_q <= timeout && !bus.io_ack;
`ifdef RV32_MEM_MISALIGN_TRAP_EN
      misalign_out <= misalign;
`endif
      case (state)
        S_IDLE: begin
          wait_cnt <= 8'd0;
          if (io_start && !bus.io_ack) begin
            state   <= S_IO_WAIT;
            q_we    <= is_store;
            q_addr  <= alu_in;
            q_be    <= lane_be;
            q_wdata <= lane_wdata;
          end
        end
        S_IO_WAIT: begin
          if (bus.io_ack || timeout) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (mem_stall) begin
        wb_enable_out  <= 1'b0;
        control_wb_out <= CWB_ALU;
      end else begin
        pc_out        <= pc_in;
        iw_out        <= iw_in;
        alu_out       <= alu_in;
        wb_reg_out    <= wb_reg_in;
        wb_enable_out <= wb_enable_in && !misalign;
        ld_fmt_out    <= {funct3, alu_in[1:0]};
        if (is_load && !misalign) control_wb_out <= is_io ? CWB_IO : CWB_MEM;
        else                      control_wb_out <= CWB_ALU;
        io_rdata_out <= (is_load && (io_start || in_wait) && bus.io_ack) ? lane_rdata : 32'b0;
      end
    end
  end

endmodule

// File: doc/rv32_mem_top.md
# rv32_mem_top

Memory-access stage of the RV32 five-stage pipeline, between EX and WB. Decodes load/store from the EX instruction word, drives the synchronous data-memory interface directly and the memory-mapped IO bus through a wait-state handshake with timeout. Registers PC, instruction, ALU result, destination register and a 2-bit `control_wb` select into WB, and publishes data-forwarding taps to the hazard unit.

## Interface
- `IO_BASE`, 4'hF: `alu_in[31:28]` value that selects IO instead of data memory.
- `IO_TIMEOUT`, 16: maximum IO wait cycles before forced completion; 1..255.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `pc_in`, `iw_in`, `alu_in` in 32 each: from EX; `alu_in` is the effective address for loads/stores.
- `rs2_in` in 32: store data.
- `wb_reg_in` in 5; `wb_enable_in` in 1: from EX.
- `mem_stall` out 1: holds IF/ID/EX while high.
- `memif_addr` out 30: word address, `alu_in[31:2]`.
- `memif_we` out 1; `memif_be` out 4; `memif_wdata` out 32.
- `io_req` out 1; `io_we` out 1; `io_addr` out 32; `io_be` out 4; `io_wdata` out 32.
- `io_ack` in 1; `io_rdata` in 32.
- `io_err` out 1: one-cycle pulse on IO timeout.
- `pc_out`, `iw_out`, `alu_out` out 32; `wb_reg_out` out 5; `wb_enable_out` out 1; `control_wb_out` out 2: registered to WB.
- `io_rdata_out` out 32: formatted IO load data to WB.
- `ld_fmt_out` out 5: registered `{funct3, alu_in[1:0]}` for WB memory-load lane extraction.
- `df_mem_enable` out 1; `df_mem_reg` out 5; `df_mem_data` out 32; `df_mem_is_load` out 1: forwarding taps.

## Operation
- Decode: load = `iw_in[6:0]==7'b0000011`, store = `7'b0100011`; `funct3 = iw_in[14:12]`; region IO when `alu_in[31:28]==IO_BASE`.
- Byte enables: SB `4'b0001<<alu_in[1:0]`; SH `4'b0011<<{alu_in[1],1'b0}`; SW `4'b1111`. Write data replicated: byte ×4, half ×2.
- Memory store: `memif_we` combinational, same cycle, no stall. Memory load: address presented, data read in WB; `control_wb_out=2'b01`.
- IO access: FSM IDLE → IO_WAIT on IO load/store; `io_req`, `io_we`, `io_addr`, `io_be`, `io_wdata` held constant through IO_WAIT; `mem_stall=1` while in IO_WAIT and on the entry cycle.
- IO_WAIT → IDLE on `io_ack` or when wait counter reaches `IO_TIMEOUT`; timeout pulses `io_err`, returns `io_rdata_out=0`.
- IO load data: on completion, byte/half extracted by `alu_in[1:0]`, sign-extended for LB/LH, zero-extended for LBU/LHU; captured into `io_rdata_out`; `control_wb_out=2'b10`.
- Non-memory instructions: `control_wb_out=2'b00`.
- `df_mem_*` are combinational from EX-side inputs: enable=`wb_enable_in`, data=`alu_in`, `df_mem_is_load`=load decode.

## Timing
- Reset: all outputs 0, FSM IDLE, counter 0, `control_wb_out=2'b00`.
- Non-IO instruction: 1-cycle latency to WB registers.
- IO access: entry cycle + N wait cycles; WB register loaded on the `io_ack` cycle (or timeout cycle). While stalled, WB registers take a bubble, with `wb_enable_out=0`.
- `io_ack` on the entry cycle completes with no extra cycle. `io_ack` in IDLE is ignored.
- Timeout: counter increments each IO_WAIT cycle; completion at count `IO_TIMEOUT`. `io_ack` on the same cycle wins, with no `io_err`.
- Reset mid-IO_WAIT drops `io_req` next edge; the transaction is abandoned.

## Configuration
- `RV32_MEM_MISALIGN_TRAP_EN`: when defined, misaligned LH/LHU/SH (`alu_in[0]`) or LW/SW (`alu_in[1:0]!=0`) suppress `memif_we`/`io_req`, force `wb_enable_out=0`, and assert registered output `misalign_out` for one cycle. When undefined, low address bits are ignored (word-aligned access, lane by enables) and `misalign_out` is absent.

## Structure
- Shared package `rv32_pkg`: opcode constants (LOAD, STORE), funct3 encodings, `control_wb` encodings (ALU=00, MEM=01, IO=10).
- One sub-module `rv32_mem_lane`: combinational byte-enable/write-replication and load extract/extend, reused by WB for memory loads via `ld_fmt_out`.

## Test plan
- SB `x`=0x000000AB to addr 0x00000102 → `memif_be=4'b0100`, `memif_wdata=0xABABABAB`, `memif_we=1`, `mem_stall=0`.
- LW from memory 0x00000010 → `memif_addr=0x4`; next cycle `control_wb_out=01`, `ld_fmt_out=5'b01000`.
- IO LB from 0xF0000003, `io_ack` after 3 cycles with `io_rdata=0x80000000` → `mem_stall` high for 4 cycles, `io_rdata_out=0xFFFFFF80`, `control_wb_out=10`.
- IO SW, no `io_ack` → after `IO_TIMEOUT`=16 wait cycles: `io_err` pulse, `io_req` low, stall released.
- Reset asserted during IO_WAIT → next cycle all outputs 0, FSM IDLE; a following ADD passes with `control_wb_out=00`.
- With `RV32_MEM_MISALIGN_TRAP_EN`, SH to 0x00000001 → `memif_we=0`, `misalign_out=1`, `wb_enable_out=0`.
